// File: rtl/freq_scan_ctrl.sv
// Periodic frequency-window scanner: walks CH_NUM meter channels once per tick
// (or on demand), tracks per-channel lock and raises sticky loss-of-lock alarms.
module freq_scan_lane #(
  parameter int MHZ_WIDTH  = 10,
  parameter int STABLE_CNT = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 eval_i,
  input  logic                 en_i,
  input  logic [MHZ_WIDTH-1:0] val_i,
  input  logic [MHZ_WIDTH-1:0] low_i,
  input  logic [MHZ_WIDTH-1:0] high_i,
  input  logic                 clr_i,
  output logic                 lock_o,
  output logic                 alarm_o
);
  localparam int STW = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;

  logic [STW-1:0] stab_q, stab_d;
  logic           lock_q, lock_d;
  logic           alarm_q, alarm_d;
  logic           in_rng;

  // An inverted window (low > high) can never satisfy both bounds.
  assign in_rng = (val_i >= low_i) && (val_i <= high_i);

  always_comb begin
    stab_d  = stab_q;
    lock_d  = lock_q;
    alarm_d = alarm_q & ~clr_i;
    if (eval_i) begin
      if (!en_i) begin
        stab_d = '0;
        lock_d = 1'b0;
      end else if (in_rng) begin
        if (stab_q != STW'(STABLE_CNT)) stab_d = stab_q + 1'b1;
        lock_d = (stab_d == STW'(STABLE_CNT));
      end else begin
        if (lock_q) alarm_d = 1'b1;
        stab_d = '0;
        lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      stab_q  <= '0;
      lock_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      stab_q  <= stab_d;
      lock_q  <= lock_d;
      alarm_q <= alarm_d;
    end
  end

  assign lock_o  = lock_q;
  assign alarm_o = alarm_q;
endmodule

module freq_scan_ctrl #(
  parameter int CH_NUM     = 4,
  parameter int MHZ_WIDTH  = 10,
  parameter int TICK_CYC   = 100000000,
  parameter int SETTLE_CYC = 16,
  parameter int STABLE_CNT = 3,
  localparam int CW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                        SYS_CLK_I,
  input  logic                        SYS_RSTN_I,
  input  logic [CH_NUM*MHZ_WIDTH-1:0] FREQ_MHZ_I,
  input  logic [CH_NUM-1:0]           CH_EN_I,
  input  logic [MHZ_WIDTH-1:0]        LOW_MHZ_I,
  input  logic [MHZ_WIDTH-1:0]        HIGH_MHZ_I,
  input  logic                        FORCE_SCAN_I,
  input  logic                        CLR_I,
  output logic [CH_NUM-1:0]           CH_LOCK_O,
  output logic [CH_NUM-1:0]           CH_ALARM_O,
  output logic                        OVERRUN_O,
  output logic [CW-1:0]               CUR_CH_O,
  output logic                        BUSY_O,
  output logic                        SCAN_DONE_O
);
  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SCAN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   per_q, per_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            tick, start_req, busy;
  logic [CH_NUM-1:0] eval;

  assign tick      = (per_q == PW'(TICK_CYC - 1));
  assign per_d     = tick ? '0 : per_q + 1'b1;
  // A tick and a forced request in the same cycle merge into one scan.
  assign start_req = tick | FORCE_SCAN_I;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ch_d     = ch_q;
    done_d   = 1'b0;
    ovr_d    = (ovr_q & ~CLR_I) | (start_req & busy);
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = SCAN;
          ch_d    = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SCAN: begin
        if (ch_q == CW'(CH_NUM - 1)) begin
          state_d = IDLE;
          ch_d    = '0;
          done_d  = 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_I) begin
    if (!SYS_RSTN_I) begin
      state_q  <= IDLE;
      per_q    <= '0;
      settle_q <= '0;
      ch_q     <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      settle_q <= settle_d;
      ch_q     <= ch_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    assign eval[k] = (state_q == SCAN) && (ch_q == CW'(k));
    freq_scan_lane #(
      .MHZ_WIDTH (MHZ_WIDTH),
      .STABLE_CNT(STABLE_CNT)
    ) u_lane (
      .clk_i  (SYS_CLK_I),
      .rstn_i (SYS_RSTN_I),
      .eval_i (eval[k]),
      .en_i   (CH_EN_I[k]),
      .val_i  (FREQ_MHZ_I[k*MHZ_WIDTH +: MHZ_WIDTH]),
      .low_i  (LOW_MHZ_I),
      .high_i (HIGH_MHZ_I),
      .clr_i  (CLR_I),
      .lock_o (CH_LOCK_O[k]),
      .alarm_o(CH_ALARM_O[k])
    );
  end

  assign OVERRUN_O   = ovr_q;
  assign CUR_CH_O    = ch_q;
  assign BUSY_O      = busy;
  assign SCAN_DONE_O = done_q;
endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Directed + randomized bench for freq_scan_ctrl against a timeline reference model.
module tb_freq_scan_ctrl;
  localparam int CH = 4, MW = 10, TK = 64, ST = 4, SC = 3;

  logic clk = 1'b0;
  logic rstn, force_scan, clr;
  logic [CH*MW-1:0] freq;
  logic [CH-1:0] en, lock, alarm;
  logic [MW-1:0] low, high;
  logic ovr, busy, done;
  logic [1:0] cur;

  always #5 clk = ~clk;

  freq_scan_ctrl #(
    .CH_NUM(CH), .MHZ_WIDTH(MW), .TICK_CYC(TK), .SETTLE_CYC(ST), .STABLE_CNT(SC)
  ) dut (
    .SYS_CLK_I(clk), .SYS_RSTN_I(rstn), .FREQ_MHZ_I(freq), .CH_EN_I(en),
    .LOW_MHZ_I(low), .HIGH_MHZ_I(high), .FORCE_SCAN_I(force_scan), .CLR_I(clr),
    .CH_LOCK_O(lock), .CH_ALARM_O(alarm), .OVERRUN_O(ovr), .CUR_CH_O(cur),
    .BUSY_O(busy), .SCAN_DONE_O(done)
  );

  int checks = 0, errors = 0;

  // Model: time since reset, position inside the current scan window (-1 = idle),
  // and per-channel length of the current run of enabled in-range readings.
  int m_t, m_pos;
  int m_run[CH];
  logic [CH-1:0] m_alarm;
  logic m_ovr, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] m_lock();
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = (m_run[k] >= SC);
    return r;
  endfunction

  task automatic eval_ch(input int k);
    int v;
    bit ok;
    v  = int'(freq[k*MW +: MW]);
    ok = (v >= int'(low)) && (v <= int'(high));
    if (en[k] && !ok && m_run[k] >= SC) m_alarm[k] = 1'b1;
    m_run[k] = (en[k] && ok) ? m_run[k] + 1 : 0;
  endtask

  task automatic model_edge();
    bit req;
    if (!rstn) begin
      m_t = 0; m_pos = -1; m_alarm = '0; m_ovr = 0; m_done = 0;
      for (int k = 0; k < CH; k++) m_run[k] = 0;
      return;
    end
    req = (m_t == TK - 1) || force_scan;
    if (clr) begin m_alarm = '0; m_ovr = 0; end
    m_done = 0;
    if (m_pos < 0) begin
      if (req) m_pos = 0;
    end else begin
      if (req) m_ovr = 1;
      if (m_pos >= ST) eval_ch(m_pos - ST);
      if (m_pos == ST + CH - 1) begin m_pos = -1; m_done = 1; end
      else m_pos++;
    end
    m_t = (m_t + 1) % TK;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", busy, m_pos >= 0);
    chk("cur", cur, (m_pos >= ST) ? m_pos - ST : 0);
    chk("done", done, m_done);
    chk("lock", lock, m_lock());
    chk("alarm", alarm, m_alarm);
    chk("ovr", ovr, m_ovr);
  endtask

  task automatic set_ch(input int k, input int v);
    freq[k*MW +: MW] = MW'(v);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    do begin step(); n++; end while (done !== 1'b1 && n < max);
    chk("wait_done", done, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin step(); n++; end
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_cur(input int c);
    int n = 0;
    while (!(busy === 1'b1 && m_pos >= ST && cur == 2'(c)) && n < 40) begin step(); n++; end
    chk("wait_cur", cur, c);
  endtask

  task automatic start_force();
    wait_idle(100);
    force_scan = 1; step(); force_scan = 0;
  endtask

  task automatic force_scans(input int n);
    repeat (n) begin start_force(); wait_done(30); end
  endtask

  task automatic pulse_clr();
    clr = 1; step(); clr = 0;
  endtask

  initial begin
    rstn = 0; force_scan = 0; clr = 0;
    freq = {CH{10'd100}}; en = '1; low = 10'd95; high = 10'd105;
    repeat (3) step();
    chk("rst_lock", lock, 0); chk("rst_alarm", alarm, 0); chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_cur", cur, 0);

    // Periodic scans: first tick 64 cycles after release, done 9 cycles after each tick.
    rstn = 1;
    repeat (63) step(); chk("pre_tick_busy", busy, 0);
    step();             chk("tick_busy", busy, 1);
    repeat (8) step();  chk("done1", done, 1); chk("lock1", lock, 4'b0000);
    repeat (64) step(); chk("done2", done, 1); chk("lock2", lock, 4'b0000);
    repeat (64) step(); chk("done3", done, 1); chk("lock3", lock, 4'b1111);

    // Loss of lock on channel 1, then clear.
    set_ch(1, 50);
    wait_done(80);
    chk("lol_lock", lock, 4'b1101); chk("lol_alarm", alarm, 4'b0010);
    pulse_clr(); chk("clr_alarm", alarm, 4'b0000);
    set_ch(1, 100);

    // Clear coinciding with an alarm set: set wins.
    force_scans(3); chk("relock", lock, 4'b1111);
    set_ch(1, 50);
    start_force(); wait_cur(1);
    clr = 1; step(); clr = 0;
    chk("clr_race_alarm", alarm[1], 1);
    wait_done(20);
    set_ch(1, 100); pulse_clr();

    // Forced request during SCAN.
    pulse_clr();
    start_force(); wait_cur(2);
    force_scan = 1; step(); force_scan = 0;
    chk("overrun", ovr, 1);
    wait_done(20);
    repeat (12) step();

    // Window edges and inverted window.
    freq = {10'd106, 10'd94, 10'd105, 10'd95};
    force_scans(3); chk("edge_lock", lock, 4'b0011);
    low = 10'd110; high = 10'd90;
    force_scans(1); chk("inv_lock", lock, 4'b0000);

    // Disabled channel.
    low = 10'd95; high = 10'd105; freq = {CH{10'd100}}; en = 4'b1011;
    pulse_clr();
    force_scans(3); chk("en_lock", lock, 4'b1011);
    set_ch(2, 50);
    force_scans(1); chk("dis_alarm", alarm[2], 0);
    set_ch(2, 100); en = '1;

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) set_ch(int'($urandom_range(CH - 1)), int'($urandom_range(108, 92)));
      if ($urandom_range(40) == 0) en = CH'($urandom_range(15, 0));
      if ($urandom_range(80) == 0) begin low = MW'($urandom_range(110, 90)); high = MW'($urandom_range(110, 90)); end
      if ($urandom_range(60) == 0) begin low = 10'd95; high = 10'd105; end
      force_scan = ($urandom_range(15) == 0);
      clr = ($urandom_range(31) == 0);
      step();
    end
    force_scan = 0; clr = 0;

    // Reset mid-scan, then tick and force together.
    low = 10'd95; high = 10'd105; freq = {CH{10'd100}}; en = '1;
    wait_idle(100);
    force_scans(3);
    start_force(); wait_cur(2);
    rstn = 0; step(); rstn = 1;
    chk("mid_rst_lock", lock, 0); chk("mid_rst_alarm", alarm, 0); chk("mid_rst_ovr", ovr, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_cur", cur, 0);
    repeat (63) step(); chk("rst_pre_tick_busy", busy, 0);
    force_scan = 1; step(); force_scan = 0;
    chk("tick_force_busy", busy, 1);
    wait_done(20);
    chk("tick_force_ovr", ovr, 0);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_scan_ctrl.md
FREQ_SCAN_CTRL -- requirements
Module: freq_scan_ctrl

Interface
REQ-001 Parameter CH_NUM, default 4: number of monitored frequency-meter channels.
REQ-002 Parameter MHZ_WIDTH, default 10: width of each channel's MHz value.
REQ-003 Parameter TICK_CYC, default 100000000: SYS_CLK_I cycles per scan period (1 s at 10 ns).
REQ-004 Parameter SETTLE_CYC, default 16: wait cycles after a tick before the scan starts, covering CDC latency of the meter outputs.
REQ-005 Parameter STABLE_CNT, default 3: consecutive in-range readings required for lock.
REQ-006 SYS_CLK_I  in  1  sole clock.
REQ-007 SYS_RSTN_I  in  1  reset, synchronous, active-low.
REQ-008 FREQ_MHZ_I  in  CH_NUM*MHZ_WIDTH  per-channel MHz value, already in the SYS_CLK_I domain; channel k occupies bits [k*MHZ_WIDTH +: MHZ_WIDTH].
REQ-009 CH_EN_I  in  CH_NUM  per-channel enable.
REQ-010 LOW_MHZ_I / HIGH_MHZ_I  in  MHZ_WIDTH each  inclusive acceptance window.
REQ-011 FORCE_SCAN_I  in  1  one-cycle pulse that requests an immediate scan.
REQ-012 CLR_I  in  1  one-cycle pulse that clears the sticky flags.
REQ-013 CH_LOCK_O  out  CH_NUM  channel stable in range.
REQ-014 CH_ALARM_O  out  CH_NUM  sticky loss-of-lock flags.
REQ-015 OVERRUN_O  out  1  sticky flag: a scan request arrived while busy.
REQ-016 CUR_CH_O  out  clog2(CH_NUM)  channel under evaluation; 0 when idle.
REQ-017 BUSY_O  out  1  high when the FSM is not in IDLE.
REQ-018 SCAN_DONE_O  out  1  one-cycle pulse when a scan completes.

Function
REQ-019 The free-running period counter SHALL count 0..TICK_CYC-1 and wrap; the wrap cycle is the tick.
REQ-020 The FSM SHALL have three states, IDLE, SETTLE and SCAN, with these transitions:
- IDLE -> SETTLE on a tick or FORCE_SCAN_I.
- SETTLE -> SCAN after exactly SETTLE_CYC cycles in SETTLE.
- SCAN -> IDLE after the last channel.
REQ-021 SCAN SHALL evaluate one channel per cycle, in order 0..CH_NUM-1; CUR_CH_O SHALL equal the channel being evaluated.
REQ-022 A channel is in range when LOW_MHZ_I <= value <= HIGH_MHZ_I, using unsigned compare; when LOW_MHZ_I > HIGH_MHZ_I, every channel is out of range.
REQ-023 Each enabled channel SHALL have a stable counter:
- An in-range reading increments it, saturating at STABLE_CNT.
- An out-of-range reading clears it to 0.
REQ-024 CH_LOCK_O[k] SHALL be 1 exactly when stable counter k equals STABLE_CNT; it SHALL update on the clock edge that ends channel k's SCAN cycle.
REQ-025 CH_ALARM_O[k] SHALL set when CH_LOCK_O[k] is 1 and channel k reads out of range.
REQ-026 A disabled channel SHALL still consume its SCAN cycle, but its stable counter and lock SHALL be forced to 0 and its alarm SHALL NOT set.
REQ-027 SCAN_DONE_O SHALL pulse in the first IDLE cycle after channel CH_NUM-1 is evaluated; scan latency from a tick is SETTLE_CYC+CH_NUM+1 cycles.
REQ-028 A tick or FORCE_SCAN_I while BUSY_O=1 SHALL be ignored and SHALL set OVERRUN_O.
REQ-029 When a tick and FORCE_SCAN_I occur together in IDLE, exactly one scan SHALL start.
REQ-030 CLR_I SHALL clear CH_ALARM_O and OVERRUN_O.
REQ-031 When CLR_I coincides with a set event, the set SHALL win for that bit.
REQ-032 CH_EN_I, LOW_MHZ_I and HIGH_MHZ_I SHALL be sampled during each channel's SCAN cycle only.
REQ-033 TICK_CYC SHALL be >= SETTLE_CYC+CH_NUM+2, so that periodic scans never overrun on their own.

Reset
REQ-034 When SYS_RSTN_I=0 at a clock edge, the following SHALL be cleared, including mid-SETTLE or mid-SCAN; the aborted scan SHALL NOT produce SCAN_DONE_O:
- period counter, FSM (to IDLE) and all stable counters;
- CH_LOCK_O, CH_ALARM_O, OVERRUN_O, CUR_CH_O, BUSY_O and SCAN_DONE_O.
REQ-035 After release, the first tick SHALL occur TICK_CYC cycles later.

Verification (CH_NUM=4, TICK_CYC=64, SETTLE_CYC=4, STABLE_CNT=3, LOW=95, HIGH=105)
REQ-036 All channels at 100 and enabled -> CH_LOCK_O=4'b1111 after the third SCAN_DONE_O, 0000 before it; SCAN_DONE_O pulses 9 cycles after each tick.
REQ-037 After lock, channel 1 set to 50 -> CH_LOCK_O[1]=0 and CH_ALARM_O[1]=1 in the same scan; a later CLR_I -> CH_ALARM_O=0.
REQ-038 Channel values 95, 105, 94, 106 -> lock pattern 4'b0011 after three scans; with LOW=110 and HIGH=90 -> no locks.
REQ-039 CH_EN_I=4'b1011 with all channels at 100 -> CH_LOCK_O=4'b1011; channel 2 never alarms.
REQ-040 Control and race cases:
- FORCE_SCAN_I during SCAN -> OVERRUN_O=1 and no extra SCAN_DONE_O.
- CLR_I in the same cycle as an alarm set -> alarm stays 1.
REQ-041 SYS_RSTN_I=0 for one cycle while CUR_CH_O=2 -> all outputs 0 on the next cycle, no SCAN_DONE_O, and the next tick arrives 64 cycles after release.
